hazard_ctrl_unit: RTL and testbench

//  Produces the forwarding selects that the execute stage consumes, plus the pipeline stall/flush

---
 rtl/hazard_ctrl_unit.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: E/M/W shadow of in-flight writers, registered execute forward selects,
// load-use / branch / mul-div stalls. Optional decode branch forwarding: HAZ_BRANCH_FWD_EN.
module hazard_ctrl_unit #(
    parameter int unsigned MD_LAT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_id5,
    input  logic [4:0] rt_id5,
    input  logic [4:0] dst_id5,
    input  logic       reg_write_id,
    input  logic       mem_to_reg_id,
    input  logic       branch_id,
    input  logic       md_start_id,
    input  logic       md_read_id,
    output logic [1:0] forward_src_a_oe2,
    output logic [1:0] forward_src_b_oe2,
    output logic       forward_a_od,
    output logic       forward_b_od,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       flush_e_o
);

    localparam int unsigned RW = 5;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 4;

    localparam logic [SW-1:0] SEL_RF  = 2'b00;
    localparam logic [SW-1:0] SEL_WB  = 2'b01;
    localparam logic [SW-1:0] SEL_MEM = 2'b10;

`ifdef HAZ_BRANCH_FWD_EN
    localparam bit BR_FWD_EN = 1'b1;
`else
    localparam bit BR_FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic          vld;
        logic [RW-1:0] dst;
        logic          rw;
        logic          ld;
    } slot_t;

    localparam slot_t BUBBLE = '{vld: 1'b0, dst: '0, rw: 1'b0, ld: 1'b0};

    slot_t         e_q, m_q, w_q;
    slot_t         d_slot;
    logic [SW-1:0] sel_a_q, sel_b_q;
    logic [SW-1:0] sel_a_d, sel_b_d;
    logic [CW-1:0] md_cnt_q;

    logic e_live, m_live;
    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
    logic md_busy;
    logic lw_stall, br_hazard, br_stall, md_stall, stall;

    // Live-writer qualification and source-register hits against E and M
    always_comb begin
        e_live   = e_q.vld && e_q.rw && (e_q.dst != '0);
        m_live   = m_q.vld && m_q.rw && (m_q.dst != '0);
        e_hit_rs = e_live && (e_q.dst == rs_id5);
        e_hit_rt = e_live && (e_q.dst == rt_id5);
        m_hit_rs = m_live && (m_q.dst == rs_id5);
        m_hit_rt = m_live && (m_q.dst == rt_id5);
    end

    // Stall sources; one combined bubble regardless of how many fire together
    always_comb begin
        md_busy   = (md_cnt_q != '0);
        lw_stall  = e_q.ld && (e_hit_rs || e_hit_rt);
        br_hazard = branch_id && ((e_hit_rs || e_hit_rt) ||
                                  (m_q.ld && (m_hit_rs || m_hit_rt)));
        br_stall  = BR_FWD_EN && br_hazard;
        md_stall  = md_busy && (md_read_id || md_start_id);
        stall     = lw_stall || br_stall || md_stall;
    end

    assign stall_f_o = stall;
    assign stall_d_o = stall;
    assign flush_e_o = stall;

    // Decode branch comparator forwarding from M alu_out (loads are stalled instead)
    assign forward_a_od = BR_FWD_EN && m_hit_rs && !m_q.ld;
    assign forward_b_od = BR_FWD_EN && m_hit_rt && !m_q.ld;

    // Next execute select: youngest producer (E, landing in M) wins over M (landing in W)
    always_comb begin
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (e_hit_rs)      sel_a_d = SEL_MEM;
        else if (m_hit_rs) sel_a_d = SEL_WB;
        if (e_hit_rt)      sel_b_d = SEL_MEM;
        else if (m_hit_rt) sel_b_d = SEL_WB;
    end

    always_comb begin
        d_slot     = BUBBLE;
        d_slot.vld = 1'b1;
        d_slot.dst = dst_id5;
        d_slot.rw  = reg_write_id;
        d_slot.ld  = mem_to_reg_id;
    end

    // Shadow pipe advances every cycle; a stalled decode enters E as a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= BUBBLE;
            m_q <= BUBBLE;
            w_q <= BUBBLE;
        end else begin
            e_q <= stall ? BUBBLE : d_slot;
            m_q <= e_q;
            w_q <= m_q;
        end
    end

    // Forward select registers; the bubble clear takes precedence over the load
    always_ff @(posedge clk) begin
        if (reset || flush_e_o) begin
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else if (!stall_d_o) begin
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign forward_src_a_oe2 = sel_a_q;
    assign forward_src_b_oe2 = sel_b_q;

    // HI/LO busy window; a new start while busy is stalled so it can never reload early
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else if (md_start_id && !stall_d_o) begin
            md_cnt_q <= CW'(MD_LAT);
        end else if (md_busy) begin
            md_cnt_q <= md_cnt_q - CW'(1);
        end
    end

    // W needs no forwarding (regfile writes first half-cycle); it just trails M
    assert property (@(posedge clk) disable iff (reset)
                     !$past(reset) |-> (w_q == $past(m_q)));

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed hazard sequences plus random traffic,
// checked against an instruction-level reference model.
module tb_hazard_ctrl_unit;

    localparam int unsigned MD_LAT = 8;
`ifdef HAZ_BRANCH_FWD_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_id5, rt_id5, dst_id5;
    logic       reg_write_id, mem_to_reg_id, branch_id, md_start_id, md_read_id;
    logic [1:0] forward_src_a_oe2, forward_src_b_oe2;
    logic       forward_a_od, forward_b_od, stall_f_o, stall_d_o, flush_e_o;

    hazard_ctrl_unit #(.MD_LAT(MD_LAT)) dut (
        .clk(clk), .reset(reset),
        .rs_id5(rs_id5), .rt_id5(rt_id5), .dst_id5(dst_id5),
        .reg_write_id(reg_write_id), .mem_to_reg_id(mem_to_reg_id),
        .branch_id(branch_id), .md_start_id(md_start_id), .md_read_id(md_read_id),
        .forward_src_a_oe2(forward_src_a_oe2), .forward_src_b_oe2(forward_src_b_oe2),
        .forward_a_od(forward_a_od), .forward_b_od(forward_b_od),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .flush_e_o(flush_e_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, dst;
        bit rw, ld, br, mds, mdr;
    } instr_t;

    typedef struct {
        bit vld;
        logic [4:0] dst;
        bit rw, ld;
    } slot_t;

    typedef struct {
        bit stall;
        logic [1:0] sa, sb;
        bit oa, ob;
        int cyc;
    } exp_t;

    exp_t   sb_q[$];
    slot_t  pipe[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     busy_until = -1;
    logic [1:0] sel_a = 2'b00, sel_b = 2'b00, nxt_a = 2'b00, nxt_b = 2'b00;
    instr_t prev_d;
    bit     prev_rst = 1'b1;
    bit     prev_stall = 1'b0;

    localparam slot_t BUB = '{vld: 1'b0, dst: 5'd0, rw: 1'b0, ld: 1'b0};

    function automatic instr_t mk(input int rs, input int rt, input int dst, input bit rw,
                                  input bit ld, input bit br, input bit mds, input bit mdr);
        instr_t i;
        i.rs = 5'(rs); i.rt = 5'(rt); i.dst = 5'(dst);
        i.rw = rw; i.ld = ld; i.br = br; i.mds = mds; i.mdr = mdr;
        return i;
    endfunction

    function automatic bit live(input slot_t s);
        return s.vld && s.rw && (s.dst != 5'd0);
    endfunction

    // Operand source for an instruction one behind E: E's result will be in M, M's in W
    function automatic logic [1:0] src_for(input logic [4:0] r);
        if (live(pipe[0]) && pipe[0].dst == r) return 2'b10;
        if (live(pipe[1]) && pipe[1].dst == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req,
                       input int c);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, req);
        end
    endtask

    // Advance the model by the clock edge that just happened
    task automatic model_update();
        slot_t s;
        if (prev_rst) begin
            pipe = {BUB, BUB, BUB};
            sel_a = 2'b00; sel_b = 2'b00;
            busy_until = -1;
        end else begin
            s = BUB;
            if (!prev_stall) begin
                s.vld = 1'b1; s.dst = prev_d.dst; s.rw = prev_d.rw; s.ld = prev_d.ld;
            end
            pipe.push_front(s);
            void'(pipe.pop_back());
            sel_a = prev_stall ? 2'b00 : nxt_a;
            sel_b = prev_stall ? 2'b00 : nxt_b;
            if (prev_d.mds && !prev_stall) busy_until = cyc + int'(MD_LAT);
        end
        cyc++;
    endtask

    // One decode cycle: drive inputs, predict this cycle's outputs, queue the prediction
    task automatic step(input instr_t d, input bit rst);
        exp_t  e;
        slot_t ee, mm;
        bit    lw, md, br, he, hm;
        @(posedge clk);
        model_update();
        #1;
        reset = rst;
        rs_id5 = d.rs; rt_id5 = d.rt; dst_id5 = d.dst;
        reg_write_id = d.rw; mem_to_reg_id = d.ld; branch_id = d.br;
        md_start_id = d.mds; md_read_id = d.mdr;
        ee = pipe[0]; mm = pipe[1];
        he = live(ee) && (ee.dst == d.rs || ee.dst == d.rt);
        hm = live(mm) && (mm.dst == d.rs || mm.dst == d.rt);
        lw = ee.ld && he;
        md = (cyc <= busy_until) && (d.mdr || d.mds);
        br = BR_EN && d.br && (he || (mm.ld && hm));
        e.stall = lw || md || br;
        e.sa = sel_a; e.sb = sel_b;
        e.oa = BR_EN && d.rs != 5'd0 && live(mm) && mm.dst == d.rs && !mm.ld;
        e.ob = BR_EN && d.rt != 5'd0 && live(mm) && mm.dst == d.rt && !mm.ld;
        e.cyc = cyc;
        nxt_a = src_for(d.rs);
        nxt_b = src_for(d.rt);
        sb_q.push_back(e);
        prev_d = d; prev_rst = rst; prev_stall = e.stall;
    endtask

    // Monitor: compare the DUT against every queued prediction mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("stall_f", 32'(stall_f_o), 32'(e.stall), e.cyc);
                chk("stall_d", 32'(stall_d_o), 32'(e.stall), e.cyc);
                chk("flush_e", 32'(flush_e_o), 32'(e.stall), e.cyc);
                chk("sel_a", 32'(forward_src_a_oe2), 32'(e.sa), e.cyc);
                chk("sel_b", 32'(forward_src_b_oe2), 32'(e.sb), e.cyc);
                chk("od_a", 32'(forward_a_od), 32'(e.oa), e.cyc);
                chk("od_b", 32'(forward_b_od), 32'(e.ob), e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        instr_t nop, d;
        int n;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        prev_d = nop;
        reset = 1'b1;
        rs_id5 = '0; rt_id5 = '0; dst_id5 = '0;
        reg_write_id = 0; mem_to_reg_id = 0; branch_id = 0; md_start_id = 0; md_read_id = 0;
        pipe = {BUB, BUB, BUB};
        step(nop, 1'b1);
        step(nop, 1'b0);
        step(nop, 1'b0);

        // T1: add r3,r1,r2 ; sub r4,r3,r1
        step(mk(1, 2, 3, 1, 0, 0, 0, 0), 1'b0);
        step(mk(3, 1, 4, 1, 0, 0, 0, 0), 1'b0);
        step(nop, 1'b0);
        step(nop, 1'b0);
        // T2: add r3 ; nop ; or r5,r1,r3
        step(mk(1, 2, 3, 1, 0, 0, 0, 0), 1'b0);
        step(nop, 1'b0);
        step(mk(1, 3, 5, 1, 0, 0, 0, 0), 1'b0);
        step(nop, 1'b0);
        step(nop, 1'b0);
        // T3: lw r2 ; add r6,r2,r2 -- exactly one stall cycle
        step(mk(1, 0, 2, 1, 1, 0, 0, 0), 1'b0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step(mk(2, 2, 6, 1, 0, 0, 0, 0), 1'b0);
            #1;
            if (stall_d_o === 1'b1) n++;
            if (!prev_stall) break;
        end
        chk("lw_stall_len", 32'(n), 32'd1, cyc);
        step(nop, 1'b0);
        step(nop, 1'b0);
        // T4: add r0 ; reader of r0
        step(mk(1, 2, 0, 1, 0, 0, 0, 0), 1'b0);
        step(mk(0, 0, 7, 1, 0, 0, 0, 0), 1'b0);
        step(nop, 1'b0);
        // T5: mult ; mflo -- stall spans the whole busy window
        step(mk(1, 2, 0, 0, 0, 0, 1, 0), 1'b0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step(mk(0, 0, 8, 1, 0, 0, 0, 1), 1'b0);
            #1;
            if (stall_d_o === 1'b1) n++;
            if (!prev_stall) break;
        end
        chk("md_stall_len", 32'(n), 32'(MD_LAT), cyc);
        // T6: reset during a load-use stall
        step(mk(1, 0, 2, 1, 1, 0, 0, 0), 1'b0);
        step(mk(2, 2, 6, 1, 0, 0, 0, 0), 1'b1);
        step(mk(2, 2, 6, 1, 0, 0, 0, 0), 1'b0);
        step(nop, 1'b0);
        // Reset mid mul/div window aborts it
        step(mk(1, 2, 0, 0, 0, 0, 1, 0), 1'b0);
        step(mk(0, 0, 8, 1, 0, 0, 0, 1), 1'b0);
        step(mk(0, 0, 8, 1, 0, 0, 0, 1), 1'b1);
        step(mk(0, 0, 8, 1, 0, 0, 0, 1), 1'b0);
        // Branch after add r3 ; nop
        step(mk(1, 2, 3, 1, 0, 0, 0, 0), 1'b0);
        step(nop, 1'b0);
        step(mk(3, 1, 0, 0, 0, 1, 0, 0), 1'b0);
        step(nop, 1'b0);
        // Branch right behind a load and right behind an ALU writer
        step(mk(1, 0, 3, 1, 1, 0, 0, 0), 1'b0);
        for (int k = 0; k < 4; k++) step(mk(3, 1, 0, 0, 0, 1, 0, 0), 1'b0);

        // Random traffic on a small register window; decode holds while stalled
        d = nop;
        for (int k = 0; k < 600; k++) begin
            bit r;
            if (!prev_stall || prev_rst) begin
                d.rs  = 5'($urandom_range(0, 3));
                d.rt  = 5'($urandom_range(0, 3));
                d.dst = 5'($urandom_range(0, 3));
                d.ld  = ($urandom_range(0, 3) == 0);
                d.br  = !d.ld && ($urandom_range(0, 5) == 0);
                d.rw  = d.ld || (!d.br && $urandom_range(0, 3) != 0);
                d.mds = ($urandom_range(0, 15) == 0);
                d.mdr = ($urandom_range(0, 7) == 0);
            end
            r = ($urandom_range(0, 79) == 0);
            step(d, r);
        end
        for (int k = 0; k < 12; k++) step(nop, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0, cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
